// File: rtl/abc_seq_pkg.sv
// Shared types and constants for the a/b/c stimulus sequencer.
package abc_seq_pkg;

  localparam int unsigned ABC_HOLD_W = 4;

  // One table step: drive values plus extra cycles to hold them.
  typedef struct packed {
    logic                  a;
    logic                  b;
    logic                  c;
    logic [ABC_HOLD_W-1:0] hold;
  } abc_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_e;

  // Value presented to the datapath whenever no run is active.
  localparam logic IDLE_A = 1'b0;
  localparam logic IDLE_B = 1'b0;
  localparam logic IDLE_C = 1'b1;

endpackage

// File: rtl/abc_seq_table.sv
// Step table: one falling-edge write port, one combinational read port.
module abc_seq_table #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned WIDTH = 7,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data_c
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Table contents survive reset, so the array has no reset branch.
  always_ff @(negedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data_c = r_mem[i_rd_addr];

endmodule

// File: rtl/abc_seq_ctrl.sv
// Replays a table of {a,b,c,hold} steps onto the datapath inputs.
// All state moves on the falling edge so the datapath samples stable values.
module abc_seq_ctrl
  import abc_seq_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned HOLD_W = 4,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned EW     = 3 + HOLD_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [EW-1:0] wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] step_idx,
  output logic          a,
  output logic          b,
  output logic          c
);

  seq_state_e        r_state, w_state_n;
  logic [AW:0]       r_len, w_len_n;
  logic [AW-1:0]     r_idx, w_idx_n;
  logic [HOLD_W-1:0] r_cnt, w_cnt_n;
  logic              r_busy, w_busy_n;
  logic              r_done, w_done_n;
  logic              r_a, w_a_n;
  logic              r_b, w_b_n;
  logic              r_c, w_c_n;

  logic [AW:0]       w_len_clamp;
  logic [AW-1:0]     w_rd_addr;
  logic [EW-1:0]     w_rd_data;
  logic              w_last;
  logic              w_wr_en;

  // Writes only land while no run is using the table.
  assign w_wr_en     = wr_en & ~r_busy;
  assign w_len_clamp = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  // Idle looks at entry 0 for the start edge; a run looks one step ahead.
  assign w_rd_addr   = (r_state == RUN) ? r_idx + AW'(1) : '0;
  assign w_last      = ((AW+1)'(r_idx) + (AW+1)'(1)) >= r_len;

  abc_seq_table #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_table (
    .clk         (clk),
    .i_wr_en     (w_wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_rd_addr   (w_rd_addr),
    .o_rd_data_c (w_rd_data)
  );

  // State and registered outputs.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_a     <= IDLE_A;
      r_b     <= IDLE_B;
      r_c     <= IDLE_C;
    end else begin
      r_state <= w_state_n;
      r_len   <= w_len_n;
      r_idx   <= w_idx_n;
      r_cnt   <= w_cnt_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_c     <= w_c_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_n = r_state;
    w_len_n   = r_len;
    w_idx_n   = r_idx;
    w_cnt_n   = r_cnt;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_c_n     = r_c;

    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          if (len == '0) begin
            w_state_n = FIN;
            w_done_n  = 1'b1;
          end else begin
            w_state_n = RUN;
            w_len_n   = w_len_clamp;
            w_idx_n   = '0;
            w_cnt_n   = w_rd_data[HOLD_W-1:0];
            w_busy_n  = 1'b1;
            w_a_n     = w_rd_data[EW-1];
            w_b_n     = w_rd_data[EW-2];
            w_c_n     = w_rd_data[EW-3];
          end
        end
      end
      RUN: begin
        if (abort || (r_cnt == '0 && w_last)) begin
          w_state_n = abort ? IDLE : FIN;
          w_done_n  = ~abort;
          w_idx_n   = '0;
          w_busy_n  = 1'b0;
          w_a_n     = IDLE_A;
          w_b_n     = IDLE_B;
          w_c_n     = IDLE_C;
        end else if (r_cnt != '0) begin
          w_cnt_n = r_cnt - HOLD_W'(1);
        end else begin
          w_idx_n = r_idx + AW'(1);
          w_cnt_n = w_rd_data[HOLD_W-1:0];
          w_a_n   = w_rd_data[EW-1];
          w_b_n   = w_rd_data[EW-2];
          w_c_n   = w_rd_data[EW-3];
        end
      end
      FIN: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign step_idx = r_idx;
  assign a        = r_a;
  assign b        = r_b;
  assign c        = r_c;

endmodule

// File: doc/abc_seq_ctrl.md
# abc_seq_ctrl

Programmable stimulus sequencer for the `seq3_1` three-signal datapath (`a`, `b`, `c`). It holds a small table of `{a,b,c,hold}` steps and replays them on command, one step per `hold+1` cycles. It sits between the bench or host (table writes, start/abort) and the DUT inputs. Outputs change on the falling clock edge, so the DUT always samples them stable.

## Interface

Parameters:
- `DEPTH`, 16: number of table entries; power of two, at least 2.
- `HOLD_W`, 4: width of the per-step hold field.

Ports (`AW = $clog2(DEPTH)`):
- `clk`  in  1  clock. All state updates on `negedge clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  table write address.
- `wr_data`  in  3+HOLD_W  `{a,b,c,hold}`, with `a` as the MSB.
- `len`  in  AW+1  number of steps to run; sampled at start.
- `start`  in  1  begin a run.
- `abort`  in  1  terminate a run.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at normal completion.
- `step_idx`  out  AW  index of the entry currently driven.
- `a`, `b`, `c`  out  1 each  drive to the DUT.

## Operation

- Idle drive value: `a=0`, `b=0`, `c=1`.
- Reset values: `busy=0`, `done=0`, `step_idx=0`, `a/b/c` at the idle drive value. The table contents are not reset.
- FSM states: IDLE, RUN, FIN.
  - IDLE → RUN: `start=1`, `abort=0`, `len≠0`.
  - IDLE → FIN: `start=1`, `abort=0`, `len=0`. This gives a `done` pulse with no drive.
  - RUN → RUN: the step's hold count has not expired, or it has expired and a next step exists.
  - RUN → FIN: the last step's hold count expires.
  - RUN → IDLE: `abort=1`. `done` is not pulsed.
  - FIN → IDLE: unconditional.
- Length handling:
  - `len > DEPTH` is clamped to `DEPTH`.
  - `len` is latched on the start edge; changes during a run are ignored.
- Step execution:
  - Step k drives its `{a,b,c}` for exactly `hold_k+1` cycles.
  - A down-counter of `HOLD_W` bits is loaded with `hold_k` on entry to the step.
- Table writes:
  - Writes are accepted only when `busy=0`. A write in the same edge as an accepted start lands, but the run reads entry 0 as it stood before the write.
  - Writes while busy are dropped.
- Signal rules:
  - `start` while busy is ignored.
  - `abort` in IDLE or FIN is ignored.
  - `start` and `abort` asserted together in IDLE: abort wins and nothing starts.
- Reset mid-run forces the reset values immediately (asynchronously). No `done` is produced.

## Timing

- Start latency:
  - `start` is sampled at falling edge N.
  - Entry 0 appears on `a/b/c` right after edge N.
  - `busy=1` and `step_idx=0` right after edge N.
- Step boundaries:
  - Step k occupies edges `S_k` through `S_k + hold_k`.
  - Step k+1 loads at edge `S_k + hold_k + 1`. There are no gap cycles.
- Completion:
  - After the last step's final cycle, the next edge enters FIN.
  - `done=1` and `busy=0` for exactly one cycle.
  - `a/b/c` return to the idle drive value at that same edge.
  - A new `start` is accepted from FIN+1 (IDLE) onward.
- Total run length from start: `sum(hold_k+1)` cycles of drive, then one FIN cycle.
- Abort: takes effect at the sampling edge. `a/b/c` are at the idle value and `busy=0` after that edge.

## Structure

- Package `abc_seq_pkg`:
  - `abc_entry_t`, a packed struct `{logic a; logic b; logic c; logic [HOLD_W-1:0] hold;}`. Its width is fixed by the package parameter, which defaults to `HOLD_W` = 4.
  - The `seq_state_e` enum: IDLE, RUN, FIN.
  - Localparams `IDLE_A/B/C`.
- Sub-module `abc_seq_table`: a `DEPTH`-entry register file with one synchronous write port (`negedge clk`) and one combinational read port. `abc_seq_ctrl` instantiates it once.

## Test plan

- Reset check:
  - Stimulus: assert `rst_n=0` mid-sim.
  - Required: `a=0`, `b=0`, `c=1`, `busy=0`, `done=0` immediately.
  - Then release reset, pulse `start` with `len=0`: exactly one `done` pulse and no change on `a/b/c`.
- Basic run:
  - Stimulus: write entries `{1,0,1,0}`, `{1,1,1,0}`, `{0,1,1,0}`, `{1,0,1,0}`, `{0,1,0,0}`, `{0,0,0,0}`; `len=6`; start.
  - Required: one step per cycle, outputs matching the table, `busy` high for 6 cycles, then `done` for 1 cycle with the idle drive value.
- Hold count:
  - Stimulus: entry 0 = `{1,1,0,3}`, entry 1 = `{0,0,0,0}`, `len=2`.
  - Required: `a=1,b=1,c=0` for 4 cycles, then entry 1 for 1 cycle, then `done`. Repeat with `hold=15` and expect 16 cycles.
- Abort mid-run:
  - Stimulus: `abort` during step 2 of a 5-step run.
  - Required: idle drive value and `busy=0` at the next edge, no `done`.
  - Follow-up: a new `start` replays from entry 0.
- Collisions:
  - `start` while busy: no restart.
  - `wr_en` while busy: table unchanged, checked by readback run.
  - `start`+`abort` in IDLE: stays IDLE.
  - `len=DEPTH+1` clamp: exactly `DEPTH` steps run.
- Reset mid-hold:
  - Stimulus: assert `rst_n` low during step 1's hold.
  - Required: immediate reset values. After release, the table is intact and a fresh run completes correctly.
